stage_wb_pipe: RTL and testbench
================================

# stage_wb_pipe

- Registered, parametrised writeback stage of the RISC-V core. Sits between the MEM stage and the register file.
- Captures the MEM-stage result, selects the writeback source, and aligns and sign-/zero-extends load data.
- Suppresses writes to x0, honours stall and flush, and drives the register-file write port plus forwarding taps.
- Optionally maintains a retired-instruction counter.

## Interface
- DATA_WIDTH, 32, datapath width; legal values 32 or 64
- REG_WIDTH, 5, register address width
- BA_WIDTH, $clog2(DATA_WIDTH/8), byte-offset width (derived, not overridden)
- i_Clock  in  1  clock, all state updates on rising edge
- i_Reset  in  1  synchronous, active-high reset
- i_Stall  in  1  hold captured state
- i_Flush  in  1  invalidate captured state
- i_Valid  in  1  MEM-stage slot holds a real instruction
- i_RegWrEnable  in  1  instruction writes rd
- i_RegWrAddr  in  REG_WIDTH  rd
- i_DataSel  in  2  source: 0 ALU, 1 LOAD, 2 PC+4, 3 CSR
- i_LoadType  in  3  funct3 of load
- i_ByteAddr  in  BA_WIDTH  low address bits of load
- i_AluResult, i_PcPlus4, i_CsrData, i_MemRdData  in  DATA_WIDTH each  source operands
- o_RegWrData  out  DATA_WIDTH  registered write data
- o_RegWrAddr  out  REG_WIDTH  registered rd
- o_RegWrEnable  out  1  registered write strobe
- o_Valid  out  1  stage holds a valid instruction
- o_Retired  out  1  one-cycle retire pulse
- o_InstRet  out  64  retired count (only with STAGE_WB_INSTRET_EN)

## Operation
- Priority each rising edge: i_Reset > i_Flush > i_Stall > capture.
- Reset: o_RegWrData=0, o_RegWrAddr=0, o_RegWrEnable=0, o_Valid=0, o_Retired=0, o_InstRet=0.
- Flush: o_Valid=0, o_RegWrEnable=0, o_Retired=0. Data and address hold. Flush with stall acts as flush.
- Stall: all registers hold except o_Retired, which is 0.
- Capture:
  - o_Valid=i_Valid.
  - o_RegWrEnable = i_Valid & i_RegWrEnable & (i_RegWrAddr != 0).
  - o_RegWrAddr=i_RegWrAddr.
  - o_RegWrData=selected source.
  - o_Retired=i_Valid.
- Load alignment: shift i_MemRdData right by 8×offset, then extend. Offset per type:
  - byte: i_ByteAddr
  - half: i_ByteAddr with bit 0 forced 0
  - word: i_ByteAddr with bits 1:0 forced 0
  - LD: offset 0
- Load extension by i_LoadType:
  - 000 LB sign-extend bit 7
  - 001 LH sign-extend bit 15
  - 010 LW full word at 32, sign-extend bit 31 at 64
  - 011 LD (64 only)
  - 100 LBU zero-extend
  - 101 LHU zero-extend
  - 110 LWU (64 only) zero-extend
- Reserved load types, and 011/110 at DATA_WIDTH=32, produce 0.
- Misaligned accesses are not trapped here: the low offset bits are dropped as above.

## Timing
- Latency: one cycle from capture edge to o_RegWrData, o_RegWrAddr, o_RegWrEnable.
- All outputs are registered; no combinational path from inputs to outputs.
- The register file writes on the edge after o_RegWrEnable is high.
- Forwarding taps are o_RegWrData, o_RegWrAddr and o_RegWrEnable, valid the same cycle.
- o_Retired is high for exactly one cycle per captured valid instruction, even if a stall then holds it.
- o_InstRet updates on the edge after o_Retired=1. It wraps from 2^64−1 to 0.
- Reset or flush mid-stall discards the held instruction. That instruction is never counted again.

## Configuration
- STAGE_WB_INSTRET_EN defined:
  - o_InstRet port and 64-bit counter present.
  - Counter increments by 1 per o_Retired pulse and resets to 0.
- Not defined: port and counter absent. o_Retired still present.

## Structure
- Shared package wb_pkg holds:
  - DataSel enum: DS_ALU, DS_LOAD, DS_PC4, DS_CSR
  - LoadType enum: LT_LB … LT_LWU
  - constant INSTRET_WIDTH=64
- Sub-module wb_load_align: combinational alignment and extension, parametrised by DATA_WIDTH.
- Source mux, pipeline register and counter live in the top module.

## Test plan
- Reset: assert i_Reset for 2 cycles with i_Valid=1 → all outputs 0. After release, first capture of ALU=0x1234, rd=5 → o_RegWrData=0x00001234, o_RegWrEnable=1 one cycle later.
- Loads, DATA_WIDTH=32, i_MemRdData=0x80FF7F01:
  - LB offset 2 → 0xFFFFFFFF
  - LBU offset 3 → 0x00000080
  - LH offset 2 → 0xFFFF80FF
  - LHU offset 0 → 0x00007F01
  - type 011 → 0
- x0 suppression: rd=0, i_RegWrEnable=1, i_Valid=1 → o_RegWrEnable=0, o_Valid=1, o_Retired=1.
- Stall/flush: capture rd=7, then i_Stall for 3 cycles → outputs held and o_Retired high only the first cycle. Then i_Flush with i_Stall → o_Valid=0, o_RegWrEnable=0.
- Source select: PC+4=0x100, CSR=0xABC → sel 2 gives 0x100, sel 3 gives 0xABC. At DATA_WIDTH=64, LWU of 0xFFFFFFFF_80000000, offset 4 → 0x00000000FFFFFFFF.
- Counter (macro on): 10 valid instructions with interleaved stalls → o_InstRet=10. Force counter to 2^64−1, retire one → 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: source-select and load-type encodings
// and the retired-instruction counter width.
package wb_pkg;

  localparam int INSTRET_WIDTH = 64;

  typedef enum logic [1:0] {
    DS_ALU  = 2'd0,
    DS_LOAD = 2'd1,
    DS_PC4  = 2'd2,
    DS_CSR  = 2'd3
  } data_sel_e;

  // Values match the funct3 field of RISC-V load instructions.
  typedef enum logic [2:0] {
    LT_LB  = 3'd0,
    LT_LH  = 3'd1,
    LT_LW  = 3'd2,
    LT_LD  = 3'd3,
    LT_LBU = 3'd4,
    LT_LHU = 3'd5,
    LT_LWU = 3'd6
  } load_type_e;

endpackage

// File: rtl/stage_wb_pipe_if.sv
// MEM-to-WB bus and register-file write/forwarding taps of the writeback stage.
// o_InstRet exists only when STAGE_WB_INSTRET_EN is defined.
interface stage_wb_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_WIDTH  = 5
);
  import wb_pkg::*;

  localparam int BA_WIDTH = $clog2(DATA_WIDTH / 8);

  // Handshake: there is no ready. i_Valid marks a real instruction in the MEM
  // slot; it is taken on every rising edge unless i_Stall (hold) or i_Flush
  // (drop) is high. o_Valid/o_Retired describe what the stage holds.
  logic                  i_Stall;
  logic                  i_Flush;
  logic                  i_Valid;
  logic                  i_RegWrEnable;
  logic [REG_WIDTH-1:0]  i_RegWrAddr;
  logic [1:0]            i_DataSel;
  logic [2:0]            i_LoadType;
  logic [BA_WIDTH-1:0]   i_ByteAddr;
  logic [DATA_WIDTH-1:0] i_AluResult;
  logic [DATA_WIDTH-1:0] i_PcPlus4;
  logic [DATA_WIDTH-1:0] i_CsrData;
  logic [DATA_WIDTH-1:0] i_MemRdData;

  logic [DATA_WIDTH-1:0] o_RegWrData;
  logic [REG_WIDTH-1:0]  o_RegWrAddr;
  logic                  o_RegWrEnable;
  logic                  o_Valid;
  logic                  o_Retired;
`ifdef STAGE_WB_INSTRET_EN
  logic [INSTRET_WIDTH-1:0] o_InstRet;
`endif

  modport master (
    output i_Stall, i_Flush, i_Valid, i_RegWrEnable, i_RegWrAddr, i_DataSel,
           i_LoadType, i_ByteAddr, i_AluResult, i_PcPlus4, i_CsrData, i_MemRdData,
`ifdef STAGE_WB_INSTRET_EN
    input  o_InstRet,
`endif
    input  o_RegWrData, o_RegWrAddr, o_RegWrEnable, o_Valid, o_Retired
  );

  modport slave (
    input  i_Stall, i_Flush, i_Valid, i_RegWrEnable, i_RegWrAddr, i_DataSel,
           i_LoadType, i_ByteAddr, i_AluResult, i_PcPlus4, i_CsrData, i_MemRdData,
`ifdef STAGE_WB_INSTRET_EN
    output o_InstRet,
`endif
    output o_RegWrData, o_RegWrAddr, o_RegWrEnable, o_Valid, o_Retired
  );

endinterface

// File: rtl/wb_load_align.sv
// Combinational load-data alignment and sign/zero extension for the WB stage.
// Misaligned offsets are not trapped: the low offset bits are simply dropped.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]               data,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]     byte_addr,
  input  logic [2:0]                          load_type,
  output logic [DATA_WIDTH-1:0]               result
);

  localparam int BA_WIDTH = $clog2(DATA_WIDTH / 8);
  localparam bit IS_64    = (DATA_WIDTH == 64);

  logic [BA_WIDTH-1:0]   offset;
  logic [DATA_WIDTH-1:0] shifted;

  always_comb begin
    offset = '0;
    case (load_type)
      LT_LB, LT_LBU: offset = byte_addr;
      LT_LH, LT_LHU: offset = byte_addr & ~BA_WIDTH'(1);
      LT_LW, LT_LWU: offset = byte_addr & ~BA_WIDTH'(3);
      default:       offset = '0;
    endcase
  end

  assign shifted = data >> {offset, 3'b000};

  // LD and LWU only exist on the 64-bit datapath; elsewhere they read as 0.
  always_comb begin
    result = '0;
    case (load_type)
      LT_LB:  result = DATA_WIDTH'($signed(shifted[7:0]));
      LT_LH:  result = DATA_WIDTH'($signed(shifted[15:0]));
      LT_LW:  result = DATA_WIDTH'($signed(shifted[31:0]));
      LT_LD:  if (IS_64) result = shifted;
      LT_LBU: result = DATA_WIDTH'(shifted[7:0]);
      LT_LHU: result = DATA_WIDTH'(shifted[15:0]);
      LT_LWU: if (IS_64) result = DATA_WIDTH'(shifted[31:0]);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/stage_wb_pipe.sv
// Registered writeback stage: source mux, x0 suppression, stall/flush, retire pulse.
// Define STAGE_WB_INSTRET_EN to add the 64-bit retired-instruction counter (o_InstRet).
module stage_wb_pipe
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_WIDTH  = 5
) (
  input  logic          i_Clock,
  input  logic          i_Reset,
  stage_wb_pipe_if.slave wb
);

  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  wr_enable;

  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [REG_WIDTH-1:0]  wr_addr_q;
  logic                  wr_enable_q;
  logic                  valid_q;
  logic                  retired_q;

  wb_load_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_load_align (
    .data      (wb.i_MemRdData),
    .byte_addr (wb.i_ByteAddr),
    .load_type (wb.i_LoadType),
    .result    (load_data)
  );

  always_comb begin
    sel_data = wb.i_AluResult;
    case (wb.i_DataSel)
      DS_ALU:  sel_data = wb.i_AluResult;
      DS_LOAD: sel_data = load_data;
      DS_PC4:  sel_data = wb.i_PcPlus4;
      DS_CSR:  sel_data = wb.i_CsrData;
      default: sel_data = wb.i_AluResult;
    endcase
  end

  // x0 is hard-wired zero, so a write to it is dropped but still retires.
  assign wr_enable = wb.i_Valid & wb.i_RegWrEnable & (wb.i_RegWrAddr != '0);

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_data_q   <= '0;
      wr_addr_q   <= '0;
      wr_enable_q <= 1'b0;
      valid_q     <= 1'b0;
      retired_q   <= 1'b0;
    end else if (wb.i_Flush) begin
      wr_enable_q <= 1'b0;
      valid_q     <= 1'b0;
      retired_q   <= 1'b0;
    end else if (wb.i_Stall) begin
      retired_q   <= 1'b0;
    end else begin
      wr_data_q   <= sel_data;
      wr_addr_q   <= wb.i_RegWrAddr;
      wr_enable_q <= wr_enable;
      valid_q     <= wb.i_Valid;
      retired_q   <= wb.i_Valid;
    end
  end

  assign wb.o_RegWrData   = wr_data_q;
  assign wb.o_RegWrAddr   = wr_addr_q;
  assign wb.o_RegWrEnable = wr_enable_q;
  assign wb.o_Valid       = valid_q;
  assign wb.o_Retired     = retired_q;

`ifdef STAGE_WB_INSTRET_EN
  logic [INSTRET_WIDTH-1:0] instret_q;

  // Counts retire pulses one edge late; wraps naturally at 2^64.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      instret_q <= '0;
    end else if (retired_q) begin
      instret_q <= instret_q + 1'b1;
    end
  end

  assign wb.o_InstRet = instret_q;
`endif

endmodule

// File: tb/tb_stage_wb_pipe.sv
// Directed bench for stage_wb_pipe: a 32-bit and a 64-bit instance share clock and reset.
// Counter checks run when STAGE_WB_INSTRET_EN is defined.
module tb_stage_wb_pipe;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  stage_wb_pipe_if #(.DATA_WIDTH(32), .REG_WIDTH(5)) if_a ();
  stage_wb_pipe_if #(.DATA_WIDTH(64), .REG_WIDTH(5)) if_b ();

  stage_wb_pipe #(.DATA_WIDTH(32), .REG_WIDTH(5)) dut_a (
    .i_Clock (clk),
    .i_Reset (rst),
    .wb      (if_a.slave)
  );

  stage_wb_pipe #(.DATA_WIDTH(64), .REG_WIDTH(5)) dut_b (
    .i_Clock (clk),
    .i_Reset (rst),
    .wb      (if_b.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];

  // 32-bit load vectors, data 0x80FF7F01
  logic [2:0]  a_lt  [8] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd3, 3'd7, 3'd2, 3'd1};
  logic [2:0]  a_off [8] = '{3'd2, 3'd3, 3'd2, 3'd0, 3'd1, 3'd0, 3'd3, 3'd3};
  logic [63:0] a_exp [8] = '{64'hFFFFFFFF, 64'h00000080, 64'hFFFF80FF, 64'h00007F01,
                             64'h0, 64'h0, 64'h80FF7F01, 64'hFFFF80FF};

  // 64-bit load vectors, data 0xFFFFFFFF_80000000
  logic [2:0]  b_lt  [6] = '{3'd6, 3'd2, 3'd2, 3'd3, 3'd0, 3'd5};
  logic [2:0]  b_off [6] = '{3'd4, 3'd4, 3'd0, 3'd5, 3'd3, 3'd6};
  logic [63:0] b_exp [6] = '{64'h00000000FFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
                             64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000,
                             64'hFFFFFFFFFFFFFF80, 64'h000000000000FFFF};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ctrl(input logic stall, input logic flush);
    if_a.i_Stall = stall;
    if_a.i_Flush = flush;
    if_b.i_Stall = stall;
    if_b.i_Flush = flush;
  endtask

  task automatic drive(input logic valid, input logic we, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [2:0] lt, input logic [2:0] off,
                       input logic [63:0] alu, input logic [63:0] pc4,
                       input logic [63:0] csr, input logic [63:0] mem);
    if_a.i_Valid       = valid;
    if_a.i_RegWrEnable = we;
    if_a.i_RegWrAddr   = rd;
    if_a.i_DataSel     = sel;
    if_a.i_LoadType    = lt;
    if_a.i_ByteAddr    = off[1:0];
    if_a.i_AluResult   = alu[31:0];
    if_a.i_PcPlus4     = pc4[31:0];
    if_a.i_CsrData     = csr[31:0];
    if_a.i_MemRdData   = mem[31:0];
    if_b.i_Valid       = valid;
    if_b.i_RegWrEnable = we;
    if_b.i_RegWrAddr   = rd;
    if_b.i_DataSel     = sel;
    if_b.i_LoadType    = lt;
    if_b.i_ByteAddr    = off;
    if_b.i_AluResult   = alu;
    if_b.i_PcPlus4     = pc4;
    if_b.i_CsrData     = csr;
    if_b.i_MemRdData   = mem;
  endtask

  initial begin
    // Reset with a valid instruction presented
    rst = 1'b1;
    ctrl(1'b0, 1'b0);
    drive(1'b1, 1'b1, 5'd3, DS_ALU, 3'd0, 3'd0, 64'h9999, 64'h0, 64'h0, 64'h0);
    tick();
    tick();
    check("rst_wdata",   if_a.o_RegWrData,   64'h0);
    check("rst_waddr",   if_a.o_RegWrAddr,   64'h0);
    check("rst_we",      if_a.o_RegWrEnable, 64'h0);
    check("rst_valid",   if_a.o_Valid,       64'h0);
    check("rst_retired", if_a.o_Retired,     64'h0);
    check("rst_b_wdata", if_b.o_RegWrData,   64'h0);

    // First capture after release
    rst = 1'b0;
    drive(1'b1, 1'b1, 5'd5, DS_ALU, 3'd0, 3'd0, 64'h1234, 64'h0, 64'h0, 64'h0);
    tick();
    check("cap_wdata",   if_a.o_RegWrData,   64'h00001234);
    check("cap_waddr",   if_a.o_RegWrAddr,   64'd5);
    check("cap_we",      if_a.o_RegWrEnable, 64'h1);
    check("cap_valid",   if_a.o_Valid,       64'h1);
    check("cap_retired", if_a.o_Retired,     64'h1);

    // 32-bit load alignment/extension
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 5'd3, DS_LOAD, a_lt[i], a_off[i], 64'h0, 64'h0, 64'h0, 64'h80FF7F01);
      exp_q.push_back(a_exp[i]);
      tick();
      check($sformatf("load32_%0d", i), if_a.o_RegWrData, exp_q.pop_front());
    end

    // x0 suppression
    drive(1'b1, 1'b1, 5'd0, DS_ALU, 3'd0, 3'd0, 64'h42, 64'h0, 64'h0, 64'h0);
    tick();
    check("x0_we",      if_a.o_RegWrEnable, 64'h0);
    check("x0_valid",   if_a.o_Valid,       64'h1);
    check("x0_retired", if_a.o_Retired,     64'h1);
    check("x0_wdata",   if_a.o_RegWrData,   64'h42);

    // Bubble: valid low
    drive(1'b0, 1'b1, 5'd6, DS_ALU, 3'd0, 3'd0, 64'h77, 64'h0, 64'h0, 64'h0);
    tick();
    check("bub_valid",   if_a.o_Valid,       64'h0);
    check("bub_we",      if_a.o_RegWrEnable, 64'h0);
    check("bub_retired", if_a.o_Retired,     64'h0);

    // Capture rd=7 then stall three cycles
    drive(1'b1, 1'b1, 5'd7, DS_ALU, 3'd0, 3'd0, 64'hDEAD, 64'h0, 64'h0, 64'h0);
    tick();
    check("st_cap_retired", if_a.o_Retired, 64'h1);
    check("st_cap_waddr",   if_a.o_RegWrAddr, 64'd7);
    ctrl(1'b1, 1'b0);
    drive(1'b1, 1'b1, 5'd9, DS_ALU, 3'd0, 3'd0, 64'h5555, 64'h0, 64'h0, 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("st%0d_wdata", i),   if_a.o_RegWrData,   64'hDEAD);
      check($sformatf("st%0d_waddr", i),   if_a.o_RegWrAddr,   64'd7);
      check($sformatf("st%0d_we", i),      if_a.o_RegWrEnable, 64'h1);
      check($sformatf("st%0d_valid", i),   if_a.o_Valid,       64'h1);
      check($sformatf("st%0d_retired", i), if_a.o_Retired,     64'h0);
    end

    // Flush together with stall
    ctrl(1'b1, 1'b1);
    tick();
    check("fl_valid",   if_a.o_Valid,       64'h0);
    check("fl_we",      if_a.o_RegWrEnable, 64'h0);
    check("fl_retired", if_a.o_Retired,     64'h0);
    check("fl_wdata",   if_a.o_RegWrData,   64'hDEAD);
    check("fl_waddr",   if_a.o_RegWrAddr,   64'd7);

    // Flush alone after a fresh capture
    ctrl(1'b0, 1'b0);
    drive(1'b1, 1'b1, 5'd4, DS_ALU, 3'd0, 3'd0, 64'hBEEF, 64'h0, 64'h0, 64'h0);
    tick();
    ctrl(1'b0, 1'b1);
    tick();
    check("fl2_valid", if_a.o_Valid,     64'h0);
    check("fl2_wdata", if_a.o_RegWrData, 64'hBEEF);
    ctrl(1'b0, 1'b0);

    // Source select on both widths
    drive(1'b1, 1'b1, 5'd2, DS_PC4, 3'd0, 3'd0, 64'h1, 64'h100, 64'hABC, 64'h2);
    tick();
    check("sel_pc4_a", if_a.o_RegWrData, 64'h100);
    check("sel_pc4_b", if_b.o_RegWrData, 64'h100);
    drive(1'b1, 1'b1, 5'd2, DS_CSR, 3'd0, 3'd0, 64'h1, 64'h100, 64'hABC, 64'h2);
    tick();
    check("sel_csr_a", if_a.o_RegWrData, 64'hABC);
    check("sel_csr_b", if_b.o_RegWrData, 64'hABC);

    // 64-bit load alignment/extension
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 5'd8, DS_LOAD, b_lt[i], b_off[i], 64'h0, 64'h0, 64'h0,
            64'hFFFFFFFF_80000000);
      exp_q.push_back(b_exp[i]);
      tick();
      check($sformatf("load64_%0d", i), if_b.o_RegWrData, exp_q.pop_front());
    end

`ifdef STAGE_WB_INSTRET_EN
    rst = 1'b1;
    drive(1'b0, 1'b0, 5'd0, DS_ALU, 3'd0, 3'd0, 64'h0, 64'h0, 64'h0, 64'h0);
    tick();
    rst = 1'b0;
    check("ir_rst", if_a.o_InstRet, 64'h0);
    for (int i = 0; i < 10; i++) begin
      ctrl(1'b0, 1'b0);
      drive(1'b1, 1'b1, 5'd1, DS_ALU, 3'd0, 3'd0, 64'(i), 64'h0, 64'h0, 64'h0);
      tick();
      ctrl(1'b1, 1'b0);
      tick();
    end
    ctrl(1'b0, 1'b0);
    drive(1'b0, 1'b0, 5'd0, DS_ALU, 3'd0, 3'd0, 64'h0, 64'h0, 64'h0, 64'h0);
    tick();
    check("ir_ten", if_a.o_InstRet, 64'd10);
    force dut_a.instret_q = {64{1'b1}};
    #1;
    release dut_a.instret_q;
    check("ir_forced", if_a.o_InstRet, {64{1'b1}});
    drive(1'b1, 1'b1, 5'd1, DS_ALU, 3'd0, 3'd0, 64'h1, 64'h0, 64'h0, 64'h0);
    tick();
    drive(1'b0, 1'b0, 5'd0, DS_ALU, 3'd0, 3'd0, 64'h0, 64'h0, 64'h0, 64'h0);
    tick();
    check("ir_wrap", if_a.o_InstRet, 64'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
